// File: rtl/fp_mult_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// exception flag bit positions, operand classes and the classifier.
package fp_mult_pkg;

   localparam int FLG_NV = 4;
   localparam int FLG_DZ = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   typedef enum logic [2:0] {
      ZERO,
      NORM,
      INF,
      QNAN,
      SNAN
   } fp_class_t;

   // Classify one operand from its field summaries. A zero exponent is
   // treated as zero whatever the mantissa holds, so subnormals flush here.
   function automatic fp_class_t classify(input logic exp_zero,
                                          input logic exp_ones,
                                          input logic man_zero,
                                          input logic quiet);
      fp_class_t c;
      if (exp_zero)
         c = ZERO;
      else if (exp_ones)
         c = man_zero ? INF : (quiet ? QNAN : SNAN);
      else
         c = NORM;
      return c;
   endfunction

endpackage

// File: rtl/fp_mult_round.sv
// Final-stage datapath of the multiplier: round-to-nearest-even, mantissa
// carry, overflow/underflow saturation, special-operand override and packing.
// Purely combinational; the parent registers the outputs.
module fp_mult_round
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                   sign,
   input  fp_class_t              class_a,
   input  fp_class_t              class_b,
   input  logic [EXP_W+1:0]       exp_n,
   input  logic [MAN_W-1:0]       mant,
   input  logic                   guard,
   input  logic                   rnd,
   input  logic                   sticky,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [4:0]             flags
);

   localparam int EMAX = (1 << EXP_W) - 1;

   logic             inc;
   logic [MAN_W:0]   mant_sum;
   logic [EXP_W+1:0] exp_f;
   logic             ovf;
   logic             unf;
   logic             inexact;
   logic             any_nan;
   logic             any_snan;
   logic             any_inf;
   logic             any_zero;

   assign inc      = guard & (rnd | sticky | mant[0]);
   assign mant_sum = {1'b0, mant} + (MAN_W+1)'(inc);
   assign exp_f    = exp_n + (EXP_W+2)'(mant_sum[MAN_W]);
   assign ovf      = ~exp_f[EXP_W+1] & (exp_f[EXP_W:0] >= (EXP_W+1)'(EMAX));
   assign unf      = exp_f[EXP_W+1] | (exp_f == '0);
   assign inexact  = guard | rnd | sticky;

   assign any_snan = (class_a == SNAN) | (class_b == SNAN);
   assign any_nan  = any_snan | (class_a == QNAN) | (class_b == QNAN);
   assign any_inf  = (class_a == INF) | (class_b == INF);
   assign any_zero = (class_a == ZERO) | (class_b == ZERO);

   // Special operands take priority over the arithmetic path; after that the
   // rounded exponent decides between saturation to inf, flush to zero, or a
   // normal packed result.
   always_comb begin
      result = '0;
      flags  = '0;
      if (any_nan | (any_inf & any_zero)) begin
         result         = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         flags[FLG_NV]  = any_snan | (any_inf & any_zero);
      end else if (any_inf) begin
         result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (any_zero) begin
         result = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      end else if (ovf) begin
         result        = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags[FLG_OF] = 1'b1;
         flags[FLG_NX] = 1'b1;
      end else if (unf) begin
         result        = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
         flags[FLG_UF] = 1'b1;
         flags[FLG_NX] = 1'b1;
      end else begin
         result        = {sign, exp_f[EXP_W-1:0], mant_sum[MAN_W-1:0]};
         flags[FLG_NX] = inexact;
      end
   end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow
// control. S1 unpacks and multiplies, S2 normalizes and extracts the rounding
// bits, S3 rounds and packs. The whole pipe advances or holds as one.
module fp_mult_pipe
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [4:0]             flags
);

   localparam int DW   = 1 + EXP_W + MAN_W;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int EW   = EXP_W + 2;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;

   logic adv;

   logic [EXP_W-1:0] ea;
   logic [EXP_W-1:0] eb;
   logic [MAN_W-1:0] ma;
   logic [MAN_W-1:0] mb;
   fp_class_t        cls_a;
   fp_class_t        cls_b;
   logic [EW-1:0]    esum_c;
   logic [PW-1:0]    mp_c;

   logic             s1_valid;
   logic             s1_sign;
   fp_class_t        s1_ca;
   fp_class_t        s1_cb;
   logic [EW-1:0]    s1_esum;
   logic [PW-1:0]    s1_mp;

   logic [PW-2:0]    mn_c;
   logic [EW-1:0]    exp_c;

   logic             s2_valid;
   logic             s2_sign;
   fp_class_t        s2_ca;
   fp_class_t        s2_cb;
   logic [EW-1:0]    s2_exp;
   logic [MAN_W-1:0] s2_mant;
   logic             s2_g;
   logic             s2_r;
   logic             s2_s;

   logic [DW-1:0]    res_c;
   logic [4:0]       flg_c;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   assign ea = a[DW-2:MAN_W];
   assign eb = b[DW-2:MAN_W];
   assign ma = a[MAN_W-1:0];
   assign mb = b[MAN_W-1:0];

   assign cls_a  = classify(ea == '0, &ea, ma == '0, ma[MAN_W-1]);
   assign cls_b  = classify(eb == '0, &eb, mb == '0, mb[MAN_W-1]);
   assign esum_c = EW'(ea) + EW'(eb) - EW'(BIAS);
   assign mp_c   = PW'({1'b1, ma}) * PW'({1'b1, mb});

   // The product of two significands lies in [1,4); align the leading one to
   // the top of mn_c, dropping it, and bump the exponent when it was >= 2.
   assign mn_c  = s1_mp[PW-1] ? s1_mp[PW-2:0] : {s1_mp[PW-3:0], 1'b0};
   assign exp_c = s1_esum + EW'(s1_mp[PW-1]);

   fp_mult_round #(
      .EXP_W(EXP_W),
      .MAN_W(MAN_W)
   ) u_round (
      .sign    (s2_sign),
      .class_a (s2_ca),
      .class_b (s2_cb),
      .exp_n   (s2_exp),
      .mant    (s2_mant),
      .guard   (s2_g),
      .rnd     (s2_r),
      .sticky  (s2_s),
      .result  (res_c),
      .flags   (flg_c)
   );

   // Valid chain and output register; reset flushes everything in flight and
   // the output only loads when a real result arrives from S2.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid) begin
            result <= res_c;
            flags  <= flg_c;
         end
      end
   end

   // S1 register: sign, operand classes, biased exponent sum and raw product.
   always_ff @(posedge clk) begin
      if (adv && in_valid) begin
         s1_sign <= a[DW-1] ^ b[DW-1];
         s1_ca   <= cls_a;
         s1_cb   <= cls_b;
         s1_esum <= esum_c;
         s1_mp   <= mp_c;
      end
   end

   // S2 register: normalized exponent, stored mantissa and guard/round/sticky.
   always_ff @(posedge clk) begin
      if (adv && s1_valid) begin
         s2_sign <= s1_sign;
         s2_ca   <= s1_ca;
         s2_cb   <= s1_cb;
         s2_exp  <= exp_c;
         s2_mant <= mn_c[2*MAN_W:MAN_W+1];
         s2_g    <= mn_c[MAN_W];
         s2_r    <= mn_c[MAN_W-1];
         s2_s    <= |mn_c[MAN_W-2:0];
      end
   end

endmodule
